// File: rtl/rc5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc5_pkg
// Description : Shared RC5-32/12/16 constants and FSM state encoding, used by
//               key expansion, the encipher core and the decipher datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package rc5_pkg;

  localparam int W     = 32;            // word width
  localparam int R     = 12;            // rounds
  localparam int T     = 2 * (R + 1);   // expanded key words per block
  localparam int T_LEN = $clog2(T);     // S RAM address width
  localparam int LOG2W = $clog2(W);     // rotate-amount width
  localparam int K_W   = $clog2(T + 1); // index counter must also hold T

  localparam logic [W-1:0]   PW     = 32'hB7E15163;
  localparam logic [W-1:0]   QW     = 32'h9E3779B9;
  localparam logic [K_W-1:0] K_LAST = K_W'(T);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rc5_state_t;

endpackage
`default_nettype wire

// File: rtl/rc5_half_round.sv
`default_nettype none
// ============================================================================
// Module      : rc5_half_round
// Description : Combinational RC5 half round: ((x ^ y) <<< y[LOG2W-1:0]) + s.
// Revision    : 1.0 - initial release
// ============================================================================
module rc5_half_round
  import rc5_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] s,
  output logic [W-1:0] r
);

  // Full word width as a shift amount; one bit wider than the rotate field.
  localparam logic [LOG2W:0] WIDTH_C = (LOG2W + 1)'(W);

  logic [W-1:0]     v_w;
  logic [LOG2W-1:0] amt_w;
  logic [W-1:0]     rot_w;

  // Data-dependent left rotate then modular add; amount 0 makes the right
  // shift a full-width shift, which yields zero and leaves v unchanged.
  always_comb begin
    v_w   = x ^ y;
    amt_w = y[LOG2W-1:0];
    rot_w = (v_w << amt_w) | (v_w >> (WIDTH_C - {1'b0, amt_w}));
    r     = rot_w + s;
  end

endmodule
`default_nettype wire

// File: rtl/rc5_encipher_core.sv
`default_nettype none
// ============================================================================
// Module      : rc5_encipher_core
// Description : Iterative RC5-32/12/16 encryption. One S word consumed per
//               cycle from the shared S RAM (1-cycle read latency); done
//               pulses T+1 edges after acceptance.
//               Optional build macro RC5_CBC_EN adds an IV/chain register
//               (IV[2W-1:W] pairs with A, IV[W-1:0] with B).
// Revision    : 1.0 - initial release
// ============================================================================
module rc5_encipher_core
  import rc5_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
`ifdef RC5_CBC_EN
  input  logic             iv_load,
  input  logic [2*W-1:0]   IV,
`endif
  input  logic [W-1:0]     S_rdata,
  output logic [T_LEN-1:0] S_addr,
  output logic             S_ren,
  output logic [W-1:0]     oA_cipher,
  output logic [W-1:0]     oB_cipher,
  output logic             busy,
  output logic             done
);

  rc5_state_t     state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic           rnd_a_q, rnd_a_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   oa_q, oa_d, ob_q, ob_d;
  logic           done_q, done_d;
`ifdef RC5_CBC_EN
  logic [2*W-1:0] chain_q, chain_d;
  logic [2*W-1:0] chain_src;
`endif

  logic [W-1:0] hr_x, hr_y, hr_out, upd;
  logic [W-1:0] a_in, b_in;

  // The A half updates A from (A,B); the B half updates B from (B,A).
  assign hr_x = rnd_a_q ? a_q : b_q;
  assign hr_y = rnd_a_q ? b_q : a_q;

  rc5_half_round u_half_round (
    .x (hr_x),
    .y (hr_y),
    .s (S_rdata),
    .r (hr_out)
  );

  // S[0] and S[1] (k = 1, 2) are plain whitening additions.
  assign upd = (k_q <= K_W'(2)) ? (hr_x + S_rdata) : hr_out;

  assign busy      = (state_q == RUN);
  assign S_ren     = (state_q == RUN) && (k_q < K_LAST);
  assign S_addr    = S_ren ? k_q[T_LEN-1:0] : '0;
  assign oA_cipher = oa_q;
  assign oB_cipher = ob_q;
  assign done      = done_q;

  // State register; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      rnd_a_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      oa_q    <= '0;
      ob_q    <= '0;
      done_q  <= 1'b0;
`ifdef RC5_CBC_EN
      chain_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rnd_a_q <= rnd_a_d;
      a_q     <= a_d;
      b_q     <= b_d;
      oa_q    <= oa_d;
      ob_q    <= ob_d;
      done_q  <= done_d;
`ifdef RC5_CBC_EN
      chain_q <= chain_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, one half round per edge in RUN.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rnd_a_d = rnd_a_q;
    a_d     = a_q;
    b_d     = b_q;
    oa_d    = oa_q;
    ob_d    = ob_q;
    done_d  = 1'b0;
`ifdef RC5_CBC_EN
    chain_d   = chain_q;
    // A same-cycle IV load is applied to the block being accepted.
    chain_src = iv_load ? IV : chain_q;
    a_in      = A ^ chain_src[2*W-1:W];
    b_in      = B ^ chain_src[W-1:0];
`else
    a_in      = A;
    b_in      = B;
`endif

    case (state_q)
      IDLE: begin
`ifdef RC5_CBC_EN
        if (iv_load) begin
          chain_d = IV;
        end
`endif
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          k_d     = '0;
          rnd_a_d = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        k_d = k_q + K_W'(1);
        // k = 0 is the address-only cycle; S[k-1] arrives from k = 1 on.
        if (k_q != '0) begin
          if (rnd_a_q) begin
            a_d = upd;
          end else begin
            b_d = upd;
          end
          rnd_a_d = ~rnd_a_q;
        end
        if (k_q == K_LAST) begin
          oa_d    = rnd_a_q ? upd : a_q;
          ob_d    = rnd_a_q ? b_q : upd;
          done_d  = 1'b1;
          k_d     = '0;
          state_d = IDLE;
`ifdef RC5_CBC_EN
          chain_d = {oa_d, ob_d};
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rc5_encipher_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc5_encipher_core
// Description : Directed self-checking bench for rc5_encipher_core. Includes
//               an S RAM model filled by a behavioural key expansion and a
//               behavioural encrypt model for vectors without published
//               answers. Honours RC5_CBC_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc5_encipher_core;

  localparam int TW = 32;
  localparam int TT = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] A, B;
  logic [TW-1:0] S_rdata;
  logic [4:0]    S_addr;
  logic          S_ren;
  logic [TW-1:0] oA_cipher, oB_cipher;
  logic          busy, done;
`ifdef RC5_CBC_EN
  logic          iv_load;
  logic [63:0]   IV;
`endif

  logic [31:0] s_mem [0:TT-1];

  int n_checks = 0;
  int n_fail   = 0;

  rc5_encipher_core dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
`ifdef RC5_CBC_EN
    .iv_load   (iv_load),
    .IV        (IV),
`endif
    .S_rdata   (S_rdata),
    .S_addr    (S_addr),
    .S_ren     (S_ren),
    .oA_cipher (oA_cipher),
    .oB_cipher (oB_cipher),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // S RAM: one-cycle synchronous read
  always @(posedge clk) begin
    if (S_ren) S_rdata <= s_mem[S_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] rotl(input logic [31:0] v, input logic [31:0] amt);
    logic [31:0] sh;
    sh = {27'd0, amt[4:0]};
    return (v << sh) | (v >> (32 - sh));
  endfunction

  // Reference RC5 key expansion for a 16-byte key (byte i = key[8i+7:8i])
  task automatic load_key(input logic [127:0] key);
    logic [31:0] L [0:3];
    logic [31:0] ka, kb;
    int i, j;
    for (int n = 0; n < 4; n++) L[n] = key[32*n +: 32];
    s_mem[0] = 32'hB7E15163;
    for (int n = 1; n < TT; n++) s_mem[n] = s_mem[n-1] + 32'h9E3779B9;
    ka = 0; kb = 0; i = 0; j = 0;
    for (int n = 0; n < 3 * TT; n++) begin
      ka = rotl(s_mem[i] + ka + kb, 32'd3);
      s_mem[i] = ka;
      kb = rotl(L[j] + ka + kb, ka + kb);
      L[j] = kb;
      i = (i + 1) % TT;
      j = (j + 1) % 4;
    end
  endtask

  // Reference RC5 encryption against the current S RAM contents
  function automatic logic [63:0] model_enc(input logic [31:0] pa, input logic [31:0] pb);
    logic [31:0] ma, mb;
    ma = pa + s_mem[0];
    mb = pb + s_mem[1];
    for (int i = 1; i <= 12; i++) begin
      ma = rotl(ma ^ mb, mb) + s_mem[2*i];
      mb = rotl(mb ^ ma, ma) + s_mem[2*i+1];
    end
    return {ma, mb};
  endfunction

  // Stimulus driver: accept one block at E0 and observe through E30.
  // Optionally raises start (with junk data) so it is sampled at E5 and E10.
  task automatic run_block(input logic [31:0] pa, input logic [31:0] pb, input bit poke,
                           output int done_at, output int n_done,
                           output int addr_err, output int busy_err);
    A = pa; B = pb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_at = -1; n_done = 0; addr_err = 0; busy_err = 0;
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (poke) begin
        start = (n == 4 || n == 9);
        A = 32'hDEADBEEF; B = 32'hCAFEF00D;
      end
      if (n <= 25) begin
        if (!(S_ren === 1'b1 && S_addr === 5'(n))) addr_err++;
      end else if (S_ren !== 1'b0) addr_err++;
      if (busy !== ((n <= 26) ? 1'b1 : 1'b0)) busy_err++;
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = n;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
`ifdef RC5_CBC_EN
    iv_load = 1'b0; IV = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({S_addr, S_ren, busy, done} !== 8'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got addr=%0d ren=%b busy=%b done=%b, want all 0", S_addr, S_ren, busy, done);
    end
    n_checks++;
    if ({oA_cipher, oB_cipher} !== 64'd0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h, want 0/0", oA_cipher, oB_cipher);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_key;
    int da, nd, ae, be;
    load_key(128'd0);
    run_block(32'h0, 32'h0, 1'b0, da, nd, ae, be);
    n_checks++;
    if (da !== 27 || nd !== 1) begin
      n_fail++; $display("FAIL zero_key_done: got first done E%0d count %0d, want E27 count 1", da, nd);
    end
    n_checks++;
    if (ae !== 0) begin
      n_fail++; $display("FAIL zero_key_saddr: got %0d bad cycles, want 0", ae);
    end
    n_checks++;
    if (be !== 0) begin
      n_fail++; $display("FAIL zero_key_busy: got %0d bad cycles, want 0", be);
    end
    n_checks++;
    if ({oA_cipher, oB_cipher} !== 64'hEEDBA521_6D8F4B15) begin
      n_fail++; $display("FAIL zero_key_ct: got %h/%h, want EEDBA521/6D8F4B15", oA_cipher, oB_cipher);
    end
  endtask

  task automatic test_start_ignored;
    int da, nd, ae, be;
    run_block(32'h0, 32'h0, 1'b1, da, nd, ae, be);
    n_checks++;
    if (da !== 27 || nd !== 1) begin
      n_fail++; $display("FAIL busy_start_done: got first done E%0d count %0d, want E27 count 1", da, nd);
    end
    n_checks++;
    if (ae !== 0) begin
      n_fail++; $display("FAIL busy_start_saddr: got %0d bad cycles, want 0", ae);
    end
    n_checks++;
    if ({oA_cipher, oB_cipher} !== 64'hEEDBA521_6D8F4B15) begin
      n_fail++; $display("FAIL busy_start_ct: got %h/%h, want EEDBA521/6D8F4B15", oA_cipher, oB_cipher);
    end
  endtask

  task automatic test_second_key;
    int da, nd, ae, be;
    load_key(128'h91CEA91001A5556351B241BE19465F91);
    run_block(32'hEEDBA521, 32'h6D8F4B15, 1'b0, da, nd, ae, be);
    n_checks++;
    if (da !== 27) begin
      n_fail++; $display("FAIL key2_done: got E%0d, want E27", da);
    end
    n_checks++;
    if ({oA_cipher, oB_cipher} !== 64'hAC13C0F7_52892B5B) begin
      n_fail++; $display("FAIL key2_ct: got %h/%h, want AC13C0F7/52892B5B", oA_cipher, oB_cipher);
    end
  endtask

  task automatic test_mid_reset;
    int da, nd, ae, be, late;
    load_key(128'd0);
    A = '0; B = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({S_addr, S_ren, busy, done} !== 8'd0 || {oA_cipher, oB_cipher} !== 64'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got addr=%0d ren=%b busy=%b done=%b ct=%h/%h, want all 0",
                         S_addr, S_ren, busy, done, oA_cipher, oB_cipher);
    end
    late = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) late++;
    end
    n_checks++;
    if (late !== 0) begin
      n_fail++; $display("FAIL mid_reset_no_done: got %0d active cycles after reset, want 0", late);
    end
    run_block(32'h0, 32'h0, 1'b0, da, nd, ae, be);
    n_checks++;
    if (da !== 27 || {oA_cipher, oB_cipher} !== 64'hEEDBA521_6D8F4B15) begin
      n_fail++; $display("FAIL post_reset_ct: got E%0d %h/%h, want E27 EEDBA521/6D8F4B15", da, oA_cipher, oB_cipher);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pa [0:2];
    logic [31:0] pb [0:2];
    logic [63:0] ex [0:2];
    int nd;
    pa[0] = 32'h0;        pb[0] = 32'h0;
    pa[1] = 32'hEEDBA521; pb[1] = 32'h6D8F4B15;
    pa[2] = 32'h12345678; pb[2] = 32'h9ABCDEF0;
    ex[0] = 64'hEEDBA521_6D8F4B15;
    ex[1] = model_enc(pa[1], pb[1]);
    ex[2] = model_enc(pa[2], pb[2]);
    nd = 0;
    A = pa[0]; B = pb[0]; start = 1'b1;
    @(posedge clk); #1;
    A = pa[1]; B = pb[1];
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        n_checks++;
        if (oA_cipher !== 32'hEEDBA521) begin
          n_fail++; $display("FAIL hold_on_start: got %h, want EEDBA521", oA_cipher);
        end
      end
      if (n == 28) begin A = pa[2]; B = pb[2]; end
      if (done === 1'b1) begin
        n_checks++;
        if (n !== 27 + 28 * nd) begin
          n_fail++; $display("FAIL b2b_timing_%0d: got E%0d, want E%0d", nd, n, 27 + 28 * nd);
        end
        n_checks++;
        if ({oA_cipher, oB_cipher} !== ex[nd]) begin
          n_fail++; $display("FAIL b2b_ct_%0d: got %h/%h, want %h", nd, oA_cipher, oB_cipher, ex[nd]);
        end
        nd++;
        if (nd == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (nd !== 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d dones, want 3", nd);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b, want 0", busy);
    end
  endtask

`ifdef RC5_CBC_EN
  task automatic test_cbc;
    int da, nd, ae, be;
    logic [63:0] ex2;
    load_key(128'd0);
    ex2 = model_enc(32'hEEDBA521, 32'h6D8F4B15);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    iv_load = 1'b1; IV = 64'd0;
    run_block(32'h0, 32'h0, 1'b0, da, nd, ae, be);
    iv_load = 1'b0;
    n_checks++;
    if ({oA_cipher, oB_cipher} !== 64'hEEDBA521_6D8F4B15) begin
      n_fail++; $display("FAIL cbc_blk1: got %h/%h, want EEDBA521/6D8F4B15", oA_cipher, oB_cipher);
    end
    run_block(32'h0, 32'h0, 1'b0, da, nd, ae, be);
    n_checks++;
    if ({oA_cipher, oB_cipher} !== ex2) begin
      n_fail++; $display("FAIL cbc_blk2: got %h/%h, want %h", oA_cipher, oB_cipher, ex2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_key();
    test_start_ignored();
    test_second_key();
    test_mid_reset();
    test_back_to_back();
`ifdef RC5_CBC_EN
    test_cbc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc5_encipher_core.md
# rc5_encipher_core

Iterative RC5-32/12/16 block encryption engine: the encrypt direction that pairs with the existing decipher datapath. It accepts one 64-bit plaintext block as two W-bit words, reads the 2(R+1) expanded round-key words from the shared S RAM produced by key expansion, and computes one S word per cycle. It returns the ciphertext words with a one-cycle done pulse. It sits between key expansion (owner of S RAM) and the block-level datapath.

## Interface
- W, 32, word width in bits
- R, 12, number of rounds
- T, 2*(R+1), number of S words read per block
- T_LEN, $clog2(T), S address width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to encrypt {A,B}; sampled only in IDLE
- A  in  W  plaintext word A; captured on the accepting edge
- B  in  W  plaintext word B; captured on the accepting edge
- S_rdata  in  W  S RAM read data; valid the cycle after S_addr/S_ren are sampled
- S_addr  out  T_LEN  S RAM read address; reset 0
- S_ren  out  1  S RAM read enable; reset 0
- oA_cipher  out  W  ciphertext word A; reset 0
- oB_cipher  out  W  ciphertext word B; reset 0
- busy  out  1  high from the cycle after acceptance until done; reset 0
- done  out  1  one-cycle pulse when oA/oB_cipher are updated; reset 0

## Operation
- States: IDLE, RUN. Index counter k runs 0..T; rnd_a flag selects the A or B half-round.
- IDLE and start=1: capture A and B, set k=0, enter RUN. start is ignored while in RUN.
- RUN: S_addr = k and S_ren = 1 while k < T. Edge j+2 after acceptance consumes S[j]:
  - j=0: A = A + S[0]
  - j=1: B = B + S[1]
  - even j ≥ 2: A = ((A ^ B) <<< B[log2W-1:0]) + S[j]
  - odd j ≥ 3: B = ((B ^ A) <<< A[log2W-1:0]) + S[j]
- All additions are modulo 2^W. Rotation is left, with amount given by the low log2(W) bits only; a rotation amount of 0 leaves the word unchanged.
- After S[T-1] is consumed: register the final A/B into oA_cipher/oB_cipher, pulse done, clear busy, return to IDLE.
- Outputs hold their value until the next done. They are not cleared on start.
- rst at any time, including mid-block: state IDLE, k=0, every output 0. A block in flight is discarded and no done is issued.

## Timing
- Acceptance edge E0. S_addr=0 with S_ren=1 during the cycle after E0.
- S[j] is consumed at edge E(j+2). done is high in the cycle after E(T+1), i.e. edge E27 for the defaults.
- A start held high during the done cycle is accepted at the next edge. Back-to-back throughput is one block per T+2 = 28 cycles.
- S_ren is low in IDLE and during the done cycle. S RAM contents must remain stable while busy=1.

## Configuration
- RC5_CBC_EN defined: adds inputs iv_load (1) and IV (2W).
  - A W-bit chain register pair, reset 0, loads IV on iv_load in IDLE.
  - At acceptance, {A,B} is XORed with the chain before whitening.
  - At done, the chain is updated with the ciphertext.
  - iv_load and start in the same IDLE cycle: the IV is loaded first, then used for that block.
- RC5_CBC_EN undefined: ECB mode, the extra ports do not exist, and the behaviour is exactly as above.

## Structure
- Package rc5_pkg: W, R, T, T_LEN, PW=32'hB7E15163, QW=32'h9E3779B9, and the state enum. The package is shared with key expansion and decipher.
- Sub-module rc5_half_round (combinational): inputs x, y, s; output ((x^y) <<< y[log2W-1:0]) + s. One instance, muxed for the A and B halves.

## Test plan
- Zero-key test: S RAM preloaded with the expansion of a 16-byte zero key, A=0, B=0 → done at E27, oA_cipher=EEDBA521, oB_cipher=6D8F4B15.
- Second key: S preloaded for key 91CEA91001A5556351B241BE19465F91, A=EEDBA521, B=6D8F4B15 → oA_cipher=AC13C0F7, oB_cipher=52892B5B. Feeding the result to the decipher datapath returns the plaintext.
- start pulsed at E5 and E10 during busy → ignored; exactly one done at E27; S_addr sequence 0..25 with no gaps.
- rst asserted at E12 → all outputs 0 next cycle, no done; a fresh block afterwards gives the zero-key vector result.
- start held high continuously → done pulses every 28 cycles, with outputs correct for each captured {A,B}.
- RC5_CBC_EN: zero key, IV=0, two consecutive zero blocks → first ciphertext EEDBA521/6D8F4B15; the second equals the encryption of that value, i.e. the same as encrypting EEDBA521/6D8F4B15 with the zero-key S table.
